// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hazard controller for a five-stage in-order pipeline.
// It issues pipeline-register load enables and bubble (flush) requests for
// load-use hazards, taken branches/jumps and data-memory wait states.
//
// Parameters:
//   MEM_TIMEOUT - consecutive mem_busy cycles after which err is raised (>= 1)
//   CNT_W       - width of the performance counters
//
// Ports:
//   clk, reset           - clock (rising edge), asynchronous active-low reset
//   id_rs, id_rt         - source register fields of the instruction in FI_ID
//   id_uses_rt           - FI_ID instruction reads rt
//   ex_memrd, ex_rt      - ID_EX instruction is a load, and its destination register
//   pcsrc                - branch taken / jump, resolved from EX_MA
//   mem_busy             - data memory not ready this cycle
//   pc_we .. ex_ma_we    - pipeline-register load enables
//   *_flush              - load a bubble into that pipeline register at the next edge
//   err                  - sticky memory-timeout flag
//   stall_cnt, flush_cnt - performance counters
//
// Build option: define HAZ_PERF_CNT_EN to build the saturating performance
// counters; without it both counter outputs are tied to zero.
//
// All control outputs are combinational from state and inputs. Priority is
// mem_busy > pcsrc > load-use.

module pipe_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_memrd,
  input  logic [4:0]       ex_rt,
  input  logic             pcsrc,
  input  logic             mem_busy,
  output logic             pc_we,
  output logic             fi_id_we,
  output logic             id_ex_we,
  output logic             ex_ma_we,
  output logic             fi_id_flush,
  output logic             id_ex_flush,
  output logic             ex_ma_flush,
  output logic             ma_wb_flush,
  output logic             err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int unsigned ToW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [ToW-1:0] ToMax = ToW'(MEM_TIMEOUT);

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StLuStall = 2'd1,
    StMemWait = 2'd2,
    StFlush   = 2'd3
  } state_e;

  state_e r_state;
  state_e w_state_nxt;

  logic w_load_use;

  // r0 is hard-wired zero, so a load targeting it never creates a dependency.
  assign w_load_use = ex_memrd && (ex_rt != 5'd0) &&
                      ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= StRun;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    pc_we       = 1'b0;
    fi_id_we    = 1'b0;
    id_ex_we    = 1'b0;
    ex_ma_we    = 1'b0;
    fi_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    ex_ma_flush = 1'b0;
    ma_wb_flush = 1'b0;

    if (!reset) begin
      // Hold everything quiet while reset is low, independent of the clock.
      w_state_nxt = StRun;
    end else if (mem_busy) begin
      // Freeze the pipe; the instruction leaving MA must not retire twice.
      ma_wb_flush = 1'b1;
      w_state_nxt = StMemWait;
    end else begin
      unique case (r_state)
        // Leaving a memory wait behaves exactly like RUN, so a pcsrc that was
        // held through the wait is honoured here.
        StRun, StMemWait: begin
          if (pcsrc) begin
            pc_we       = 1'b1;
            fi_id_we    = 1'b1;
            id_ex_we    = 1'b1;
            ex_ma_we    = 1'b1;
            fi_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            ex_ma_flush = 1'b1;
            w_state_nxt = StFlush;
          end else if (w_load_use) begin
            // Hold PC and FI_ID, insert a bubble behind the load.
            id_ex_we    = 1'b1;
            ex_ma_we    = 1'b1;
            id_ex_flush = 1'b1;
            w_state_nxt = StLuStall;
          end else begin
            pc_we       = 1'b1;
            fi_id_we    = 1'b1;
            id_ex_we    = 1'b1;
            ex_ma_we    = 1'b1;
            w_state_nxt = StRun;
          end
        end

        // The load has moved on; re-detecting would stall a second time.
        StLuStall: begin
          pc_we    = 1'b1;
          fi_id_we = 1'b1;
          id_ex_we = 1'b1;
          ex_ma_we = 1'b1;
          if (pcsrc) begin
            fi_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            ex_ma_flush = 1'b1;
            w_state_nxt = StFlush;
          end else begin
            w_state_nxt = StRun;
          end
        end

        // The redirect already squashed the wrong-path instructions; pcsrc and
        // load-use seen now belong to squashed instructions and are ignored.
        StFlush: begin
          pc_we       = 1'b1;
          fi_id_we    = 1'b1;
          id_ex_we    = 1'b1;
          ex_ma_we    = 1'b1;
          w_state_nxt = StRun;
        end

        default: begin
          w_state_nxt = StRun;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Memory timeout detection
  // ---------------------------------------------------------------------------
  logic [ToW-1:0] r_to_cnt;
  logic [ToW-1:0] w_to_cnt_nxt;
  logic           r_err;
  logic           w_err_nxt;

  always_comb begin
    w_to_cnt_nxt = r_to_cnt;
    if (!mem_busy) begin
      w_to_cnt_nxt = '0;
    end else if (r_to_cnt != ToMax) begin
      w_to_cnt_nxt = r_to_cnt + ToW'(1);
    end
    w_err_nxt = r_err || (mem_busy && (w_to_cnt_nxt == ToMax));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_to_cnt <= '0;
      r_err    <= 1'b0;
    end else begin
      r_to_cnt <= w_to_cnt_nxt;
      r_err    <= w_err_nxt;
    end
  end

  assign err = r_err;

  // ---------------------------------------------------------------------------
  // Performance counters
  // ---------------------------------------------------------------------------
`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (!pc_we && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      if (fi_id_flush && (r_flush_cnt != '1)) begin
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: a hand-computed vector table,
// directed multi-cycle sequences, and random stimulus against a history-based
// reference model. Honours HAZ_PERF_CNT_EN for the counter expectations.

module tb_pipe_hazard_ctrl;

  localparam int unsigned MemTimeout = 255;
  localparam int unsigned CntW       = 16;
  localparam longint      CntMax     = (64'd1 << CntW) - 1;
`ifdef HAZ_PERF_CNT_EN
  localparam bit PerfEn = 1'b1;
`else
  localparam bit PerfEn = 1'b0;
`endif

  // Kind of decision the pipeline took in the previous cycle.
  localparam int KNorm   = 0;
  localparam int KBranch = 1;
  localparam int KLu     = 2;
  localparam int KBusy   = 3;

  logic            clk;
  logic            reset;
  logic [4:0]      id_rs;
  logic [4:0]      id_rt;
  logic            id_uses_rt;
  logic            ex_memrd;
  logic [4:0]      ex_rt;
  logic            pcsrc;
  logic            mem_busy;
  logic            pc_we;
  logic            fi_id_we;
  logic            id_ex_we;
  logic            ex_ma_we;
  logic            fi_id_flush;
  logic            id_ex_flush;
  logic            ex_ma_flush;
  logic            ma_wb_flush;
  logic            err;
  logic [CntW-1:0] stall_cnt;
  logic [CntW-1:0] flush_cnt;

  pipe_hazard_ctrl #(
    .MEM_TIMEOUT(MemTimeout),
    .CNT_W      (CntW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_uses_rt (id_uses_rt),
    .ex_memrd   (ex_memrd),
    .ex_rt      (ex_rt),
    .pcsrc      (pcsrc),
    .mem_busy   (mem_busy),
    .pc_we      (pc_we),
    .fi_id_we   (fi_id_we),
    .id_ex_we   (id_ex_we),
    .ex_ma_we   (ex_ma_we),
    .fi_id_flush(fi_id_flush),
    .id_ex_flush(id_ex_flush),
    .ex_ma_flush(ex_ma_flush),
    .ma_wb_flush(ma_wb_flush),
    .err        (err),
    .stall_cnt  (stall_cnt),
    .flush_cnt  (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] w_we;
  logic [3:0] w_fl;
  assign w_we = {pc_we, fi_id_we, id_ex_we, ex_ma_we};
  assign w_fl = {fi_id_flush, id_ex_flush, ex_ma_flush, ma_wb_flush};

  typedef struct {
    bit         mb;
    bit         pc;
    bit         memrd;
    logic [4:0] ex_rt;
    logic [4:0] rs;
    logic [4:0] rt;
    bit         uses_rt;
    logic [3:0] we;
    logic [3:0] fl;
  } vec_t;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  // Reference model state
  int     m_kind;
  int     m_busy_run;
  bit     m_err;
  longint m_stall;
  longint m_flush;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s (cycle %0d): got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  function automatic vec_t mk(input bit mb, input bit pc, input bit memrd, input int ert,
                              input int rs, input int rt, input bit ur,
                              input logic [3:0] we, input logic [3:0] fl);
    vec_t v;
    v.mb      = mb;
    v.pc      = pc;
    v.memrd   = memrd;
    v.ex_rt   = 5'(ert);
    v.rs      = 5'(rs);
    v.rt      = 5'(rt);
    v.uses_rt = ur;
    v.we      = we;
    v.fl      = fl;
    return v;
  endfunction

  function automatic vec_t mk_in(input bit mb, input bit pc, input bit memrd, input int ert,
                                 input int rs, input int rt, input bit ur);
    return mk(mb, pc, memrd, ert, rs, rt, ur, 4'b0000, 4'b0000);
  endfunction

  task automatic model_reset();
    m_kind     = KNorm;
    m_busy_run = 0;
    m_err      = 1'b0;
    m_stall    = 0;
    m_flush    = 0;
  endtask

  // Drives one cycle starting at a falling edge; returns at the next falling edge.
  task automatic step(input vec_t v, input bit use_tbl);
    logic [3:0] e_we;
    logic [3:0] e_fl;
    int         nk;
    bit         lu;
    mem_busy   = v.mb;
    pcsrc      = v.pc;
    ex_memrd   = v.memrd;
    ex_rt      = v.ex_rt;
    id_rs      = v.rs;
    id_rt      = v.rt;
    id_uses_rt = v.uses_rt;
    #1;
    lu = v.memrd && (v.ex_rt != 0) && ((v.ex_rt == v.rs) || (v.uses_rt && (v.ex_rt == v.rt)));
    if (v.mb) begin
      e_we = 4'b0000; e_fl = 4'b0001; nk = KBusy;
    end else if (m_kind == KBranch) begin
      e_we = 4'b1111; e_fl = 4'b0000; nk = KNorm;
    end else if (v.pc) begin
      e_we = 4'b1111; e_fl = 4'b1110; nk = KBranch;
    end else if (lu && (m_kind != KLu)) begin
      e_we = 4'b0011; e_fl = 4'b0100; nk = KLu;
    end else begin
      e_we = 4'b1111; e_fl = 4'b0000; nk = KNorm;
    end
    check("we_model", 32'(w_we), 32'(e_we));
    check("flush_model", 32'(w_fl), 32'(e_fl));
    if (use_tbl) begin
      check("we_table", 32'(w_we), 32'(v.we));
      check("flush_table", 32'(w_fl), 32'(v.fl));
    end
    @(posedge clk);
    m_kind = nk;
    if (v.mb) m_busy_run++;
    else m_busy_run = 0;
    if (m_busy_run >= int'(MemTimeout)) m_err = 1'b1;
    if (!e_we[3] && (m_stall < CntMax)) m_stall++;
    if (e_fl[3] && (m_flush < CntMax)) m_flush++;
    #1;
    cyc++;
    check("err_model", 32'(err), 32'(m_err));
    check("stall_cnt_model", 32'(stall_cnt), PerfEn ? 32'(m_stall) : 32'd0);
    check("flush_cnt_model", 32'(flush_cnt), PerfEn ? 32'(m_flush) : 32'd0);
    @(negedge clk);
  endtask

  // Asserts reset with whatever inputs are currently applied, checks the
  // immediate reset response, then releases on a falling edge.
  task automatic hard_reset();
    reset = 1'b0;
    #1;
    check("rst_we", 32'(w_we), 32'd0);
    check("rst_flush", 32'(w_fl), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    check("rst_flush_cnt", 32'(flush_cnt), 32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  vec_t tbl[17];

  initial begin
    tbl[0]  = mk(0, 0, 0, 0, 0, 0, 0, 4'b1111, 4'b0000);  // idle
    tbl[1]  = mk(0, 0, 1, 7, 7, 0, 0, 4'b0011, 4'b0100);  // load-use on rs
    tbl[2]  = mk(0, 0, 1, 7, 7, 0, 0, 4'b1111, 4'b0000);  // suppressed in stall
    tbl[3]  = mk(0, 0, 1, 0, 0, 0, 0, 4'b1111, 4'b0000);  // r0 never hazards
    tbl[4]  = mk(0, 0, 1, 5, 3, 5, 1, 4'b0011, 4'b0100);  // load-use on rt
    tbl[5]  = mk(0, 1, 0, 0, 0, 0, 0, 4'b1111, 4'b1110);  // branch from stall
    tbl[6]  = mk(0, 1, 1, 5, 5, 0, 0, 4'b1111, 4'b0000);  // ignored in flush
    tbl[7]  = mk(0, 0, 1, 5, 3, 5, 0, 4'b1111, 4'b0000);  // rt match, rt unused
    tbl[8]  = mk(0, 1, 1, 5, 5, 0, 0, 4'b1111, 4'b1110);  // pcsrc beats load-use
    tbl[9]  = mk(1, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0001);  // busy in flush
    tbl[10] = mk(1, 1, 0, 0, 0, 0, 0, 4'b0000, 4'b0001);  // busy beats pcsrc
    tbl[11] = mk(0, 1, 0, 0, 0, 0, 0, 4'b1111, 4'b1110);  // held pcsrc honoured
    tbl[12] = mk(0, 0, 0, 0, 0, 0, 0, 4'b1111, 4'b0000);
    tbl[13] = mk(0, 0, 1, 9, 9, 0, 0, 4'b0011, 4'b0100);
    tbl[14] = mk(1, 0, 1, 9, 9, 0, 0, 4'b0000, 4'b0001);  // busy in stall
    tbl[15] = mk(0, 0, 1, 9, 9, 0, 0, 4'b0011, 4'b0100);  // wait exit acts as run
    tbl[16] = mk(0, 0, 0, 0, 0, 0, 0, 4'b1111, 4'b0000);

    mem_busy   = 1'b0;
    pcsrc      = 1'b0;
    ex_memrd   = 1'b0;
    ex_rt      = '0;
    id_rs      = '0;
    id_rt      = '0;
    id_uses_rt = 1'b0;

    // Vector table from a clean reset
    hard_reset();
    for (int i = 0; i < 17; i++) step(tbl[i], 1'b1);

    // Branch held two cycles: one flush, then FLUSH, then RUN
    hard_reset();
    step(mk(0, 1, 0, 0, 0, 0, 0, 4'b1111, 4'b1110), 1'b1);
    step(mk(0, 1, 0, 0, 0, 0, 0, 4'b1111, 4'b0000), 1'b1);
    step(tbl[0], 1'b1);
    check("flush_cnt_branch", 32'(flush_cnt), PerfEn ? 32'd1 : 32'd0);

    // Four busy cycles with pcsrc pending, then the redirect
    hard_reset();
    for (int i = 0; i < 4; i++) step(mk(1, 1, 0, 0, 0, 0, 0, 4'b0000, 4'b0001), 1'b1);
    step(mk(0, 1, 0, 0, 0, 0, 0, 4'b1111, 4'b1110), 1'b1);
    check("stall_cnt_busy4", 32'(stall_cnt), PerfEn ? 32'd4 : 32'd0);

    // Memory timeout
    hard_reset();
    for (int i = 0; i < 254; i++) step(mk_in(1, 0, 0, 0, 0, 0, 0), 1'b0);
    check("err_before_timeout", 32'(err), 32'd0);
    step(mk_in(1, 0, 0, 0, 0, 0, 0), 1'b0);
    check("err_at_timeout", 32'(err), 32'd1);
    for (int i = 0; i < 45; i++) step(mk_in(1, 0, 0, 0, 0, 0, 0), 1'b0);
    for (int i = 0; i < 3; i++) step(mk_in(0, 0, 0, 0, 0, 0, 0), 1'b0);
    check("err_sticky", 32'(err), 32'd1);

    // Reset in the middle of a memory wait
    step(mk_in(1, 0, 0, 0, 0, 0, 0), 1'b0);
    step(mk_in(1, 1, 1, 2, 2, 0, 0), 1'b0);
    hard_reset();
    mem_busy = 1'b0;
    step(mk(0, 0, 0, 0, 0, 0, 0, 4'b1111, 4'b0000), 1'b1);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      step(mk_in(($urandom_range(0, 7) == 0), ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 1) == 1), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                 ($urandom_range(0, 1) == 1)), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, 255: max consecutive mem_busy cycles before err.
REQ-002 SHALL have parameter CNT_W, 16: width of the performance counters.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port id_rs, input, 5: rs field of the instruction in FI_ID.
REQ-006 SHALL have port id_rt, input, 5: rt field of the instruction in FI_ID.
REQ-007 SHALL have port id_uses_rt, input, 1: FI_ID instruction reads rt.
REQ-008 SHALL have port ex_memrd, input, 1: MemRd of the instruction in ID_EX.
REQ-009 SHALL have port ex_rt, input, 5: load destination register of the instruction in ID_EX.
REQ-010 SHALL have port pcsrc, input, 1: branch taken or jump, resolved from EX_MA.
REQ-011 SHALL have port mem_busy, input, 1: data memory not ready this cycle.
REQ-012 SHALL have ports pc_we, fi_id_we, id_ex_we, ex_ma_we, each output, 1: register load enables.
REQ-013 SHALL have ports fi_id_flush, id_ex_flush, ex_ma_flush, ma_wb_flush, each output, 1: load a bubble at the next edge.
REQ-014 SHALL have port err, output, 1: sticky memory-timeout flag.
REQ-015 SHALL have ports stall_cnt and flush_cnt, each output, CNT_W: performance counters.

Function
REQ-016 SHALL implement FSM states RUN, LU_STALL, MEM_WAIT and FLUSH; all outputs are combinational from state and inputs.
REQ-017 SHALL apply priority mem_busy > pcsrc > load-use in RUN, LU_STALL and FLUSH.
REQ-018 SHALL, whenever mem_busy=1 in any state:
- drive all *_we=0, ma_wb_flush=1 and all other flushes 0;
- enter or stay in MEM_WAIT.
REQ-019 SHALL exit MEM_WAIT when mem_busy=0 and evaluate pcsrc and load-use that same cycle as in RUN; a pcsrc held during the wait SHALL be honoured then.
REQ-020 SHALL, in RUN with pcsrc=1:
- drive fi_id_flush=id_ex_flush=ex_ma_flush=1 and all *_we=1;
- go to FLUSH.
REQ-021 SHALL, in FLUSH, ignore pcsrc and load-use, drive all *_we=1 with no flushes, and return to RUN after exactly one cycle.
REQ-022 SHALL detect load-use when ex_memrd=1, ex_rt!=0, and ex_rt==id_rs or (id_uses_rt=1 and ex_rt==id_rt).
REQ-023 SHALL, on load-use in RUN:
- drive pc_we=0, fi_id_we=0, id_ex_flush=1, id_ex_we=1, ex_ma_we=1;
- go to LU_STALL.
REQ-024 SHALL, in LU_STALL, suppress load-use detection, drive all *_we=1 with no flushes, and return to RUN after one cycle; pcsrc SHALL still be honoured per REQ-020.
REQ-025 SHALL, in RUN with no event, drive all *_we=1 and all flushes 0.
REQ-026 SHALL count consecutive mem_busy cycles, and set err when the count reaches MEM_TIMEOUT; err holds until reset, and the counter clears when mem_busy=0.

Reset
REQ-027 SHALL, while reset=0:
- force state RUN, err=0, timeout counter 0 and both performance counters 0;
- drive all *_we=0 and all flushes 0.
REQ-028 SHALL resume in RUN with REQ-025 outputs on the first edge after reset rises; an operation interrupted mid-stall is abandoned, not resumed.

Configuration
REQ-029 SHALL, with macro HAZ_PERF_CNT_EN defined:
- increment stall_cnt each cycle with pc_we=0;
- increment flush_cnt each cycle with fi_id_flush=1;
- saturate both at all-ones.
REQ-030 SHALL, without HAZ_PERF_CNT_EN, tie stall_cnt and flush_cnt to 0 and instantiate no counter flops.

Verification
REQ-031 SHALL cover: ex_memrd=1, ex_rt=7, id_rs=7 in RUN -> one cycle with pc_we=0 and id_ex_flush=1, then LU_STALL, then RUN.
REQ-032 SHALL cover: ex_memrd=1, ex_rt=0, id_rs=0 -> no stall, pc_we=1.
REQ-033 SHALL cover: pcsrc=1 for 2 cycles -> three flushes asserted in the first cycle only, FLUSH, then RUN; flush_cnt=1.
REQ-034 SHALL cover: mem_busy=1 for 4 cycles with pcsrc=1 -> all *_we=0 for 4 cycles, flush issued in cycle 5; stall_cnt=4.
REQ-035 SHALL cover: mem_busy held 300 cycles, MEM_TIMEOUT=255 -> err=1 after 255 busy cycles and remains 1 after mem_busy=0.
REQ-036 SHALL cover: reset=0 asserted mid-MEM_WAIT -> outputs immediately per REQ-027, RUN after release, counters 0.
